// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per power-of-two shift distance,
// supporting rotate right/left, logical and arithmetic shift right with a valid/ready stream.
module pipelined_barrel_shifter #(
  parameter  int unsigned WIDTH  = 8,
  localparam int unsigned STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  inData,
  input  logic [STAGES-1:0] shiftAmount,
  input  logic [1:0]        mode,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  outData,
  output logic              outLost
);

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_ROL = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  data;
    logic [STAGES-1:0] amt;
    mode_e             mode;
    logic              lost;
  } stage_t;

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 2..64");
  end

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  logic   advance;

  // The whole pipeline moves together; empty slots are never squeezed out.
  assign advance = !outValid || outReady;
  assign inReady = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned D = 32'd1 << k;

    stage_t src;
    stage_t nxt;

    if (k == 0) begin : g_src
      assign src = '{valid: inValid, data: inData, amt: shiftAmount,
                     mode: mode_e'(mode), lost: 1'b0};
    end else begin : g_src
      assign src = stage_q[k-1];
    end

    // Stage k moves by 2^k when amount bit k is set.
    always_comb begin
      nxt = src;
      if (src.amt[k]) begin
        unique case (src.mode)
          MODE_ROR: nxt.data = {src.data[D-1:0], src.data[WIDTH-1:D]};
          MODE_ROL: nxt.data = {src.data[WIDTH-D-1:0], src.data[WIDTH-1:WIDTH-D]};
          MODE_LSR: begin
            nxt.data = {{D{1'b0}}, src.data[WIDTH-1:D]};
            nxt.lost = src.lost | (|src.data[D-1:0]);
          end
          MODE_ASR: begin
            nxt.data = {{D{src.data[WIDTH-1]}}, src.data[WIDTH-1:D]};
            nxt.lost = src.lost | (|src.data[D-1:0]);
          end
        endcase
      end
    end

    assign stage_d[k] = nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign outValid = stage_q[STAGES-1].valid;
  assign outData  = stage_q[STAGES-1].data;
  assign outLost  = stage_q[STAGES-1].lost;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH 8, 2 and 32:
// table-driven mode/boundary vectors plus reset, backpressure and throughput sequences.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        i8_valid, i8_ready, o8_valid, o8_ready, o8_lost;
  logic [7:0]  i8_data, o8_data;
  logic [2:0]  i8_amt;
  logic [1:0]  i8_mode;

  logic        i2_valid, i2_ready, o2_valid, o2_ready, o2_lost;
  logic [1:0]  i2_data, o2_data;
  logic [0:0]  i2_amt;
  logic [1:0]  i2_mode;

  logic        i32_valid, i32_ready, o32_valid, o32_ready, o32_lost;
  logic [31:0] i32_data, o32_data;
  logic [4:0]  i32_amt;
  logic [1:0]  i32_mode;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .inValid(i8_valid), .inReady(i8_ready), .inData(i8_data),
    .shiftAmount(i8_amt), .mode(i8_mode), .outValid(o8_valid), .outReady(o8_ready),
    .outData(o8_data), .outLost(o8_lost));

  pipelined_barrel_shifter #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .inValid(i2_valid), .inReady(i2_ready), .inData(i2_data),
    .shiftAmount(i2_amt), .mode(i2_mode), .outValid(o2_valid), .outReady(o2_ready),
    .outData(o2_data), .outLost(o2_lost));

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .inValid(i32_valid), .inReady(i32_ready), .inData(i32_data),
    .shiftAmount(i32_amt), .mode(i32_mode), .outValid(o32_valid), .outReady(o32_ready),
    .outData(o32_data), .outLost(o32_lost));

  typedef struct {
    int          w;
    logic [63:0] data;
    int          amt;
    logic [1:0]  mode;
    logic [63:0] exp_data;
    logic        exp_lost;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int w, input logic [63:0] d, input int a, input logic [1:0] m,
                     input logic [63:0] ed, input logic el);
    vec_t v;
    v.w = w; v.data = d; v.amt = a; v.mode = m; v.exp_data = ed; v.exp_lost = el;
    vecs.push_back(v);
  endtask

  // Bit-by-bit reference; returns {lost, data}.
  function automatic logic [64:0] model(input int w, input logic [63:0] x, input int amt,
                                        input logic [1:0] m);
    logic [63:0] r;
    logic        lost;
    r = '0;
    lost = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = x[(i + amt) % w];
        2'b01:   r[(i + amt) % w] = x[i];
        default: r[i] = (i + amt < w) ? x[i + amt] : ((m == 2'b11) ? x[w-1] : 1'b0);
      endcase
      if (m[1] && i < amt && x[i]) lost = 1'b1;
    end
    return {lost, r};
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [63:0] d, input int a,
                          input logic [1:0] m);
    i8_valid = 1'b0; i2_valid = 1'b0; i32_valid = 1'b0;
    case (w)
      8:  begin i8_valid  = v; i8_data  = d[7:0];  i8_amt  = 3'(a); i8_mode  = m; end
      2:  begin i2_valid  = v; i2_data  = d[1:0];  i2_amt  = 1'(a); i2_mode  = m; end
      default: begin i32_valid = v; i32_data = d[31:0]; i32_amt = 5'(a); i32_mode = m; end
    endcase
  endtask

  task automatic get_out(input int w, output logic v, output logic [63:0] d, output logic l);
    case (w)
      8:  begin v = o8_valid;  d = 64'(o8_data);  l = o8_lost;  end
      2:  begin v = o2_valid;  d = 64'(o2_data);  l = o2_lost;  end
      default: begin v = o32_valid; d = 64'(o32_data); l = o32_lost; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        v, l;
    logic [63:0] d;
    logic [64:0] m;
    logic [8:0]  expq[$];
    logic [8:0]  held, e;
    logic [7:0]  lfsr;
    logic        stall_prev;
    int          lat, sent, rcvd, rx;

    // W8 modes and boundaries
    add(8, 64'h96, 3, 2'b00, 64'hD2, 1'b0);
    add(8, 64'h96, 3, 2'b01, 64'hB4, 1'b0);
    add(8, 64'h96, 3, 2'b10, 64'h12, 1'b1);
    add(8, 64'h96, 3, 2'b11, 64'hF2, 1'b1);
    add(8, 64'hA5, 0, 2'b00, 64'hA5, 1'b0);
    add(8, 64'hA5, 0, 2'b01, 64'hA5, 1'b0);
    add(8, 64'hA5, 0, 2'b10, 64'hA5, 1'b0);
    add(8, 64'hA5, 0, 2'b11, 64'hA5, 1'b0);
    add(8, 64'h80, 7, 2'b10, 64'h01, 1'b0);
    add(8, 64'h80, 7, 2'b11, 64'hFF, 1'b0);
    add(8, 64'h81, 7, 2'b10, 64'h01, 1'b1);
    add(8, 64'h01, 7, 2'b00, 64'h02, 1'b0);
    add(8, 64'h80, 1, 2'b01, 64'h01, 1'b0);
    add(8, 64'h7F, 4, 2'b11, 64'h07, 1'b1);
    // W2
    add(2, 64'h2, 1, 2'b00, 64'h1, 1'b0);
    add(2, 64'h2, 1, 2'b01, 64'h1, 1'b0);
    add(2, 64'h2, 1, 2'b10, 64'h1, 1'b0);
    add(2, 64'h2, 1, 2'b11, 64'h3, 1'b0);
    add(2, 64'h1, 1, 2'b10, 64'h0, 1'b1);
    add(2, 64'h1, 1, 2'b11, 64'h0, 1'b1);
    add(2, 64'h1, 0, 2'b11, 64'h1, 1'b0);
    // W32
    add(32, 64'h960000F1, 4,  2'b00, 64'h1960000F, 1'b0);
    add(32, 64'h960000F1, 4,  2'b01, 64'h60000F19, 1'b0);
    add(32, 64'h960000F1, 4,  2'b10, 64'h0960000F, 1'b1);
    add(32, 64'h960000F1, 4,  2'b11, 64'hF960000F, 1'b1);
    add(32, 64'h80000000, 31, 2'b11, 64'hFFFFFFFF, 1'b0);
    add(32, 64'h80000001, 31, 2'b10, 64'h00000001, 1'b1);
    add(32, 64'h00000001, 31, 2'b01, 64'h80000000, 1'b0);

    // Reset with operands presented: nothing accepted
    rst_n = 1'b0;
    o8_ready = 1'b1; o2_ready = 1'b1; o32_ready = 1'b1;
    drive_in(2, 1'b1, 64'h3, 1, 2'b11);
    drive_in(32, 1'b1, 64'hFFFF, 3, 2'b00);
    drive_in(8, 1'b1, 64'h5A, 2, 2'b00);
    i2_valid = 1'b1; i32_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid8", 64'(o8_valid), 64'(0));
    check("rst_out_data8", 64'(o8_data), 64'(0));
    check("rst_out_lost8", 64'(o8_lost), 64'(0));
    check("rst_in_ready8", 64'(i8_ready), 64'(1));
    check("rst_out_valid2", 64'(o2_valid), 64'(0));
    check("rst_out_valid32", 64'(o32_valid), 64'(0));
    rst_n = 1'b1;
    drive_in(8, 1'b0, 64'h0, 0, 2'b00);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("post_rst_no_output", 64'(o8_valid), 64'(0));
    end

    // Table vectors: exact latency STAGES, then result
    for (int i = 0; i < vecs.size(); i++) begin
      drive_in(vecs[i].w, 1'b1, vecs[i].data, vecs[i].amt, vecs[i].mode);
      lat = $clog2(vecs[i].w);
      @(posedge clk);
      for (int j = 1; j <= lat; j++) begin
        @(negedge clk);
        if (j == 1) drive_in(vecs[i].w, 1'b0, 64'h0, 0, 2'b00);
        get_out(vecs[i].w, v, d, l);
        check($sformatf("vec%0d_valid_cyc%0d", i, j), 64'(v), 64'(j == lat));
        if (j == lat) begin
          check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
          check($sformatf("vec%0d_lost", i), 64'(l), 64'(vecs[i].exp_lost));
        end
      end
    end
    repeat (6) @(negedge clk);

    // Backpressure stream of 10 operands
    lfsr = 8'hA7; sent = 0; rcvd = 0; stall_prev = 1'b0; held = '0;
    for (int c = 0; c < 400 && rcvd < 10; c++) begin
      @(negedge clk);
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      o8_ready = lfsr[0];
      drive_in(8, sent < 10, 64'(8'(sent * 37 + 5)), sent % 8, 2'(sent));
      #1;
      if (stall_prev) begin
        check("bp_hold_valid", 64'(o8_valid), 64'(1));
        check("bp_hold_data", 64'({o8_lost, o8_data}), 64'(held));
      end
      check("bp_in_ready", 64'(i8_ready), 64'(!(o8_valid && !o8_ready)));
      if (i8_valid && i8_ready) begin
        m = model(8, 64'(i8_data), int'(i8_amt), i8_mode);
        expq.push_back({m[64], m[7:0]});
        sent++;
      end
      if (o8_valid && o8_ready) begin
        if (expq.size() == 0) begin
          check("bp_unexpected_out", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          check($sformatf("bp_out%0d", rcvd), 64'({o8_lost, o8_data}), 64'(e));
        end
        rcvd++;
      end
      stall_prev = o8_valid && !o8_ready;
      held = {o8_lost, o8_data};
    end
    check("bp_count", 64'(rcvd), 64'(10));

    // Full throughput: 64 back-to-back operands
    @(negedge clk);
    o8_ready = 1'b1;
    drive_in(8, 1'b0, 64'h0, 0, 2'b00);
    repeat (4) @(negedge clk);
    rx = 0;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      drive_in(8, c < 64, 64'(c), c % 8, 2'(c % 4));
      #1;
      if (o8_valid) begin
        check("tp_cycle", 64'(c), 64'(rx + 3));
        m = model(8, 64'(rx), rx % 8, 2'(rx % 4));
        check($sformatf("tp_out%0d", rx), 64'({o8_lost, o8_data}), 64'({m[64], m[7:0]}));
        rx++;
      end
    end
    check("tp_count", 64'(rx), 64'(64));

    // Mid-flight reset with 3 operands in the pipeline, none transferred
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_in(8, 1'b1, 64'hFF, 1, 2'b00);
    end
    @(negedge clk);
    drive_in(8, 1'b0, 64'h0, 0, 2'b00);
    o8_ready = 1'b0;
    #1;
    check("mid_full_before_rst", 64'(o8_valid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", 64'(o8_valid), 64'(0));
    check("mid_rst_data", 64'(o8_data), 64'(0));
    check("mid_rst_in_ready", 64'(i8_ready), 64'(1));
    o8_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("mid_rst_no_output", 64'(o8_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
